// File: rtl/clockworks_divider.sv
// clockworks_divider: clock gearbox for the system clock.
//   SLOW == 0 : clk is a straight wire from CLK and fe is held at 1, so every
//               CLK cycle counts as a falling-edge event.
//   SLOW >= 1 : a free-running SLOW-bit counter. clk is taken directly from its
//               top bit, so clk has no glitches and runs at CLK/2^SLOW with a
//               50% duty cycle. fe flags the CLK cycle whose closing edge
//               drops clk.
// Ports:
//   CLK  in   board clock
//   clk  out  divided system clock
//   fe   out  falling-edge event qualifier, synchronous to CLK
module clockworks_divider #(
  parameter int SLOW = 0
) (
  input  logic CLK,
  output logic clk,
  output logic fe
);

  generate
    if (SLOW == 0) begin : g_pass
      assign clk = CLK;
      assign fe  = 1'b1;
    end else begin : g_div
      // The counter has no reset, so the reset button can never truncate a clk phase.
      logic [SLOW-1:0] div_r = '0;

      // Free-running divide counter that wraps from all-ones to zero.
      always_ff @(posedge CLK) begin
        div_r <= div_r + SLOW'(1);
      end

      assign clk = div_r[SLOW-1];
      // The all-ones count is the last CLK cycle of the clk high phase.
      assign fe  = &div_r;
    end
  endgenerate

endmodule

// File: rtl/clockworks.sv
// clockworks: clock gearbox and reset stretcher at the top of the SoC.
// resetn is held low for RST_HOLD clk falling-edge events after RESET is
// released. It changes only on falling-edge events, so it is stable around
// every clk rising edge.
// Build option: when CLOCKWORKS_SIM_PASSTHRU_EN is defined, SLOW is ignored.
// clk then equals CLK and the hold count runs in CLK cycles, which lets
// simulation run at full speed with the same reset behaviour.
// Ports:
//   CLK     in   board clock; all flops in this block use its rising edge
//   RESET   in   synchronous active-high reset; may be a single CLK cycle
//   clk     out  system clock (CLK/2^SLOW, or CLK itself)
//   resetn  out  stretched active-low system reset
module clockworks #(
  parameter int SLOW     = 0,
  parameter int RST_HOLD = 16
) (
  input  logic CLK,
  input  logic RESET,
  output logic clk,
  output logic resetn
);

  localparam int              HOLD_W    = 16;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD);
`ifdef CLOCKWORKS_SIM_PASSTHRU_EN
  localparam int SLOW_EFF = 0;
`else
  localparam int SLOW_EFF = SLOW;
`endif

  logic              fe_s;
  logic [HOLD_W-1:0] hold_r   = HOLD_INIT;
  // After configuration the system starts in reset, even with no RESET pulse.
  logic              resetn_r = 1'b0;

  clockworks_divider #(
    .SLOW (SLOW_EFF)
  ) u_divider (
    .CLK (CLK),
    .clk (clk),
    .fe  (fe_s)
  );

  // Hold counter: RESET reloads it at any time; it counts down on falling-edge events.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hold_r <= HOLD_INIT;
    end else if (fe_s && (hold_r != {HOLD_W{1'b0}})) begin
      hold_r <= hold_r - HOLD_W'(1);
    end else begin
      hold_r <= hold_r;
    end
  end

  // resetn updates only on falling-edge events and uses the values from before this edge.
  always_ff @(posedge CLK) begin
    if (fe_s) begin
      resetn_r <= (hold_r == {HOLD_W{1'b0}}) && !RESET;
    end else begin
      resetn_r <= resetn_r;
    end
  end

  assign resetn = resetn_r;

endmodule

// File: tb/tb_clockworks.sv
// tb_clockworks: scoreboard bench for four clockworks instances.
// Each instance has its own SLOW and RST_HOLD setting and its own reset schedule.
// Before every CLK edge, a behavioural model computes the expected clk and
// resetn for each instance and pushes them to a queue. Just after the edge the
// bench pops each entry and compares it with the instance outputs.
module tb_clockworks;

  logic       CLK = 1'b0;
  logic [3:0] rst = 4'b0000;
  logic [3:0] clk_s;
  logic [3:0] rn_s;

  always #5 CLK = ~CLK;

  clockworks #(.SLOW(0), .RST_HOLD(4)) u0 (.CLK(CLK), .RESET(rst[0]), .clk(clk_s[0]), .resetn(rn_s[0]));
  clockworks #(.SLOW(3), .RST_HOLD(2)) u1 (.CLK(CLK), .RESET(rst[1]), .clk(clk_s[1]), .resetn(rn_s[1]));
  clockworks #(.SLOW(2), .RST_HOLD(3)) u2 (.CLK(CLK), .RESET(rst[2]), .clk(clk_s[2]), .resetn(rn_s[2]));
  clockworks #(.SLOW(1), .RST_HOLD(3)) u3 (.CLK(CLK), .RESET(rst[3]), .clk(clk_s[3]), .resetn(rn_s[3]));

  typedef struct {
    int   dut;
    logic ck;
    logic rn;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int slow_of(input int i);
    case (i)
      0:       return 0;
      1:       return 3;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int hold_of(input int i);
    case (i)
      0:       return 4;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  // Fixed reset schedule: the value RESET has at CLK edge number c.
  function automatic logic rst_sched(input int i, input int c);
    case (i)
      0:       return (c == 30) || (c == 31);          // 2-cycle pulse once running
      1:       return (c <= 9) || (c == 60);           // long reset, later a 1-cycle pulse
      2:       return (c <= 2) || (c == 9) || (c == 70); // c == 9 lands while hold == 1
      default: return (c == 20) || (c == 24) || (c == 50);
    endcase
  endfunction

  // Model state: CLK-cycle phase, falling-edge events since RESET was last seen, expected resetn.
  int   cnt_m[4]   = '{0, 0, 0, 0};
  int   since_m[4] = '{0, 0, 0, 0};
  logic rn_m[4]    = '{1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    logic r;
    logic fe;
    logic ck;
    logic pclk3;
    logic prn3;
    int   s;
    int   h;
    exp_t e;

    for (int c = 0; c < 160; c++) begin
      if (c > 0) begin
        @(negedge CLK);
        #1;
        check_value($sformatf("clk0_low_c%0d", c), 32'(clk_s[0]), 32'd0);
      end
      for (int i = 0; i < 4; i++) begin
        r = rst_sched(i, c) | ((c >= 100) && ($urandom_range(0, 24) == 0));
        rst[i] = r;
        s = slow_of(i);
        h = hold_of(i);
        fe = (s == 0) ? 1'b1 : (cnt_m[i] == (1 << s) - 1);
        if (s > 0) cnt_m[i] = (cnt_m[i] + 1) % (1 << s);
        if (r) begin
          since_m[i] = 0;
          if (fe) rn_m[i] = 1'b0;
        end else if (fe) begin
          if (since_m[i] <= h) since_m[i]++;
          rn_m[i] = (since_m[i] >= h + 1);
        end
        ck = (s == 0) ? 1'b1 : (cnt_m[i] >= (1 << (s - 1)));
        sb.push_back('{i, ck, rn_m[i]});
      end
      pclk3 = clk_s[3];
      prn3  = rn_s[3];
      @(posedge CLK);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check_value($sformatf("clk%0d_c%0d", e.dut, c), 32'(clk_s[e.dut]), 32'(e.ck));
        check_value($sformatf("resetn%0d_c%0d", e.dut, c), 32'(rn_s[e.dut]), 32'(e.rn));
      end
      if (!pclk3 && clk_s[3]) begin
        check_value($sformatf("resetn3_stable_at_rise_c%0d", c), 32'(rn_s[3]), 32'(prn3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
